// File: rtl/counter_regfile.sv
// ---------------------------------------------------------------------------
// counter_regfile
//
// Small register file in which every entry can be loaded, incremented or
// decremented in place. A sequential clear walks the whole array one entry
// per clock. Sticky flags record increment wrap (ovf) and decrement-at-zero
// saturation (unf).
//
// Parameters
//   WIDTH  register data width in bits
//   DEPTH  number of registers (2..16)
//   AW     address width, DEPTH <= 2**AW
//
// Ports
//   CLK          rising-edge clock
//   reset        asynchronous active-low reset
//   WE           operation enable
//   op[1:0]      00 load WB, 01 increment, 10 decrement (saturating), 11 no-op
//   dest[AW-1:0] destination register address
//   WB           load data
//   srcA, srcB   combinational read addresses
//   R1, R2       read data for srcA / srcB (0 for out-of-range addresses)
//   zeroA/zeroB  R1 == 0 / R2 == 0
//   clr_req      start the sequential clear (ignored while busy)
//   busy         clear sequence in progress
//   ovf, unf     sticky overflow / underflow flags
//   flag_clr     synchronous clear of ovf and unf (wins over a same-cycle set)
//   o_dbg_state  current FSM state (0 = IDLE, 1 = CLEAR)
//   o_dbg_idx    current clear index
//
// Handshake: there is no ready signal. An operation presented with WE=1 is
// taken at the next rising edge only when the FSM is IDLE, clr_req is low
// and dest addresses an existing register; otherwise it is dropped.
// ---------------------------------------------------------------------------
module counter_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             WE,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    dest,
  input  logic [WIDTH-1:0] WB,
  input  logic [AW-1:0]    srcA,
  input  logic [AW-1:0]    srcB,
  output logic [WIDTH-1:0] R1,
  output logic [WIDTH-1:0] R2,
  output logic             zeroA,
  output logic             zeroB,
  input  logic             clr_req,
  output logic             busy,
  output logic             ovf,
  output logic             unf,
  input  logic             flag_clr,
  output logic             o_dbg_state,
  output logic [AW-1:0]    o_dbg_idx
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;

  // One extra bit so DEPTH == 2**AW is still representable for the
  // range compares.
  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_idx;
  logic [AW-1:0]     w_idx_nxt;
  logic [WIDTH-1:0]  r_regs [DEPTH];
  logic              r_ovf;
  logic              r_unf;

  logic              w_in_idle;
  logic              w_dest_ok;
  logic              w_a_ok;
  logic              w_b_ok;
  logic              w_op_en;
  logic [WIDTH-1:0]  w_cur;
  logic [WIDTH-1:0]  w_reg_nxt;
  logic              w_wr;
  logic              w_ovf_set;
  logic              w_unf_set;

  // -------------------------------------------------------------------------
  // Address qualification
  // -------------------------------------------------------------------------
  assign w_in_idle = (r_state == ST_IDLE);
  assign w_dest_ok = ({1'b0, dest} < DEPTH_EXT);
  assign w_a_ok    = ({1'b0, srcA} < DEPTH_EXT);
  assign w_b_ok    = ({1'b0, srcB} < DEPTH_EXT);

  // A clr_req seen in IDLE starts the clear and swallows any same-cycle op.
  assign w_op_en   = WE && w_in_idle && !clr_req && w_dest_ok;
  assign w_cur     = w_dest_ok ? r_regs[dest] : '0;

  // -------------------------------------------------------------------------
  // Operation datapath
  // -------------------------------------------------------------------------
  always_comb begin
    w_reg_nxt = w_cur;
    w_wr      = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (w_op_en) begin
      case (op)
        OP_LOAD: begin
          w_wr      = 1'b1;
          w_reg_nxt = WB;
        end
        OP_INC: begin
          w_wr      = 1'b1;
          w_reg_nxt = w_cur + WIDTH'(1);
          w_ovf_set = &w_cur;
        end
        OP_DEC: begin
          // Saturate at zero: value stays 0 and the event is flagged.
          if (w_cur == '0) begin
            w_unf_set = 1'b1;
          end else begin
            w_wr      = 1'b1;
            w_reg_nxt = w_cur - WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Clear sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_idx_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        // clr_req is deliberately not looked at here: no restart.
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt   = r_idx + AW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Register array
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (r_state == ST_CLEAR) begin
      r_regs[r_idx] <= '0;
    end else if (w_wr) begin
      r_regs[dest] <= w_reg_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky flags (frozen while clearing)
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (w_in_idle) begin
      if (flag_clr) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end else begin
        if (w_ovf_set) r_ovf <= 1'b1;
        if (w_unf_set) r_unf <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: reads are straight from the array, no write bypass.
  // -------------------------------------------------------------------------
  assign R1          = w_a_ok ? r_regs[srcA] : '0;
  assign R2          = w_b_ok ? r_regs[srcB] : '0;
  assign zeroA       = (R1 == '0);
  assign zeroB       = (R2 == '0);
  assign busy        = (r_state == ST_CLEAR);
  assign ovf         = r_ovf;
  assign unf         = r_unf;
  assign o_dbg_state = r_state;
  assign o_dbg_idx   = r_idx;

endmodule

// File: doc/counter_regfile.md
COUNTER_REGFILE -- requirements
Module: counter_regfile

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning register data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning number of registers (2..16).
REQ-003 The block SHALL have parameter AW, default 2, meaning address width, with DEPTH <= 2**AW.
REQ-004 The block SHALL have port CLK, input, 1 bit: single clock, rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port WE, input, 1 bit: operation enable.
REQ-007 The block SHALL have port op, input, 2 bits: 00 load WB, 01 increment, 10 decrement, 11 no-op.
REQ-008 The block SHALL have port dest, input, AW bits: destination register address.
REQ-009 The block SHALL have port WB, input, WIDTH bits: load data.
REQ-010 The block SHALL have ports srcA and srcB, input, AW bits each: read addresses.
REQ-011 The block SHALL have ports R1 and R2, output, WIDTH bits each: read data for srcA and srcB.
REQ-012 The block SHALL have ports zeroA and zeroB, output, 1 bit each: R1 == 0 and R2 == 0.
REQ-013 The block SHALL have port clr_req, input, 1 bit: request a sequential clear of all registers.
REQ-014 The block SHALL have port busy, output, 1 bit: clear sequence in progress.
REQ-015 The block SHALL have ports ovf and unf, output, 1 bit each: sticky overflow and underflow flags.
REQ-016 The block SHALL have port flag_clr, input, 1 bit: synchronous clear of ovf and unf.

Function
REQ-017 Reads SHALL be combinational from the register array; a write is visible on R1/R2 only after the writing edge, with no bypass.
REQ-018 An out-of-range read address (>= DEPTH) SHALL return 0; an out-of-range dest SHALL make the operation a no-op with no flag change.
REQ-019 With WE=1, busy=0 and op=00, reg[dest] SHALL load WB at the next edge.
REQ-020 With op=01, reg[dest] SHALL become reg[dest]+1 modulo 2**WIDTH; wrapping from all-ones to 0 SHALL set ovf.
REQ-021 With op=10, a nonzero reg[dest] SHALL become reg[dest]-1; at 0 it SHALL hold 0 (saturate) and set unf.
REQ-022 With op=11 or WE=0, registers SHALL be unchanged.
REQ-023 The FSM SHALL have two states, IDLE and CLEAR, and a clear index idx of AW bits.
REQ-024 In IDLE, clr_req=1 SHALL move the FSM to CLEAR with idx=0, and any WE operation in that same cycle SHALL be ignored.
REQ-025 In CLEAR, each edge SHALL zero reg[idx] and increment idx; at idx=DEPTH-1 the FSM SHALL return to IDLE.
REQ-026 busy SHALL be high for exactly DEPTH cycles, during CLEAR only.
REQ-027 WE operations while busy=1 SHALL be ignored.
REQ-028 clr_req while busy=1 SHALL be ignored and SHALL NOT restart the sequence.
REQ-029 flag_clr=1 SHALL clear ovf and unf at the next edge, and SHALL take priority over a same-cycle flag set.
REQ-030 Flags SHALL NOT change during CLEAR.

Reset
REQ-031 reset=0 SHALL asynchronously set all registers to 0, the FSM to IDLE, idx to 0, busy to 0, ovf and unf to 0, and therefore zeroA and zeroB to 1.
REQ-032 Reset asserted mid-CLEAR SHALL abort the sequence immediately.
REQ-033 After reset deassertion, the first edge SHALL accept an operation.

Verification
REQ-034 The bench SHALL cover: reset -> R1=R2=0, zeroA=zeroB=1, busy=0, ovf=unf=0.
REQ-035 The bench SHALL cover: load reg2=8'hFE, then two increments -> reg2=FF, then 00 with ovf=1; then flag_clr -> ovf=0.
REQ-036 The bench SHALL cover: decrement of reg1=1 twice -> 0, then holds 0 with unf=1; zeroA=1 with srcA=1.
REQ-037 The bench SHALL cover: load all 4 registers to 8'h55, pulse clr_req -> busy high for 4 cycles, registers zero in order 0..3, and a WE load during busy has no effect.
REQ-038 The bench SHALL cover: srcA=srcB=dest=3 with load 8'hA5 -> R1=R2=old value until the edge, then A5 on both.
REQ-039 The bench SHALL cover: reset asserted on the 2nd CLEAR cycle -> busy=0 immediately and all registers 0; after release, clr_req restarts from idx 0.
